// File: rtl/imm_ext_arbiter.sv
// ---------------------------------------------------------------------------
// imm_ext_arbiter
//
// Shares one 16-to-32-bit immediate extender between two requesters:
//   port 0 : branch-offset generation
//   port 1 : ALU immediate path
// Requests are round-robin arbitrated, extended by sign_extend_16x32, and
// held in a single-entry registered output buffer until the consumer takes
// them. A drain and a refill may happen in the same cycle.
//
// Configuration macro: IMM_ARB_ZEXT_EN
//   defined   : reqN_zext=1 selects zero-extension for that request
//   undefined : reqN_zext ports are present but ignored (always sign-extend)
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req0_valid/data/zext/ready   port 0 request handshake
//   req1_valid/data/zext/ready   port 1 request handshake
//   rsp_valid, rsp_ready         output buffer handshake
//   rsp_data                     extended result
//   rsp_id                       originating port of rsp_data
// ---------------------------------------------------------------------------

module sign_extend_16x32 #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  data,
  input  logic             zext,
  output logic [OUT_W-1:0] result
);

  logic fill;

  always_comb begin
    fill   = zext ? 1'b0 : data[IN_W-1];
    result = {{(OUT_W-IN_W){fill}}, data};
  end

endmodule

module imm_ext_arbiter #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [IN_W-1:0]  req0_data,
  input  logic             req0_zext,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IN_W-1:0]  req1_data,
  input  logic             req1_zext,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_id
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state;
  logic            last_grant;
  logic            can_accept;
  logic            grant0;
  logic            grant1;
  logic            accept0;
  logic            accept1;
  logic            accept;
  logic [IN_W-1:0] sel_data;
  logic            sel_zext;
  logic [OUT_W-1:0] ext_result;

  // Buffer can take a new result when empty, or when the current one
  // leaves this same cycle.
  assign can_accept = (state == ST_EMPTY) | rsp_ready;

  // Round-robin: a lone requester always wins; under contention the port
  // that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Ready is gated by rst so no accept can occur in a reset cycle.
  assign req0_ready = grant0 & can_accept & ~rst;
  assign req1_ready = grant1 & can_accept & ~rst;

  assign accept0 = req0_valid & req0_ready;
  assign accept1 = req1_valid & req1_ready;
  assign accept  = accept0 | accept1;

  assign sel_data = accept1 ? req1_data : req0_data;

`ifdef IMM_ARB_ZEXT_EN
  assign sel_zext = accept1 ? req1_zext : req0_zext;
`else
  logic unused_zext;
  assign unused_zext = req0_zext ^ req1_zext;
  assign sel_zext    = 1'b0;
`endif

  sign_extend_16x32 #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .data   (sel_data),
    .zext   (sel_zext),
    .result (ext_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      state      <= ST_FULL;
      rsp_data   <= ext_result;
      rsp_id     <= accept1;
      last_grant <= accept1;
    end else if ((state == ST_FULL) && rsp_ready) begin
      state <= ST_EMPTY;
    end
  end

  assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imm_ext_arbiter
//
// Scoreboard bench for imm_ext_arbiter. A reference model process predicts
// grants/readys from the arbitration rules and pushes expected results into
// a queue on each predicted accept; a monitor process pops and compares
// whenever the DUT hands a result over. Directed phases cover the listed
// scenarios, followed by a randomized phase.
// ---------------------------------------------------------------------------

module tb_imm_ext_arbiter;

`ifdef IMM_ARB_ZEXT_EN
  localparam bit ZEXT = 1'b1;
`else
  localparam bit ZEXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_zext, req0_ready;
  logic [15:0] req0_data;
  logic        req1_valid, req1_zext, req1_ready;
  logic [15:0] req1_data;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;

  imm_ext_arbiter #(.IN_W(16), .OUT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_zext  (req0_zext),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_zext  (req1_zext),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic        id;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] seen_data[$];
  logic        seen_id[$];

  // Model state: buffer occupancy after the coming edge, last granted port.
  bit m_full = 1'b0;
  int m_last = 1;
  bit acc0   = 1'b0;
  bit acc1   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic z);
    if (ZEXT && z) return {16'h0000, d};
    return d[15] ? (32'hFFFF0000 + {16'h0000, d}) : {16'h0000, d};
  endfunction

  // Reference model: evaluated mid-cycle, inputs stable until the next edge.
  initial begin
    int g;
    bit can, e0, e1;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        check("ready0_in_reset", {31'd0, req0_ready}, 32'd0);
        check("ready1_in_reset", {31'd0, req1_ready}, 32'd0);
        sb.delete();
        m_full = 1'b0;
        m_last = 1;
        acc0   = 1'b0;
        acc1   = 1'b0;
      end else begin
        g = -1;
        if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
        can = !m_full || rsp_ready;
        e0  = (g == 0) && can;
        e1  = (g == 1) && can;
        check("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        acc0 = e0;
        acc1 = e1;
        if (e0) begin
          sb.push_back('{data: ref_ext(req0_data, req0_zext), id: 1'b0});
          m_last = 0;
          m_full = 1'b1;
        end else if (e1) begin
          sb.push_back('{data: ref_ext(req1_data, req1_zext), id: 1'b1});
          m_last = 1;
          m_full = 1'b1;
        end else if (m_full && rsp_ready) begin
          m_full = 1'b0;
        end
      end
    end
  end

  // Monitor: runs before the model each cycle, so the queue front is the
  // result the DUT should currently be presenting.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, (sb.size() != 0)});
        if (rsp_valid && sb.size() != 0) begin
          check("rsp_data", rsp_data, sb[0].data);
          check("rsp_id", {31'd0, rsp_id}, {31'd0, sb[0].id});
          if (rsp_ready) begin
            void'(sb.pop_front());
            seen_data.push_back(rsp_data);
            seen_id.push_back(rsp_id);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_data = '0; req0_zext = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_zext = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
  endtask

  task automatic clear_log();
    seen_data.delete();
    seen_id.delete();
  endtask

  initial begin
    logic [31:0] exp_d;
    bit p0, p1;
    idle_inputs();
    rsp_ready = 1'b1;
    rst = 1'b1;
    tick();
    do_reset();

    // Sign extension on each port.
    clear_log();
    req0_valid = 1'b1; req0_data = 16'h8888;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 16'h7FFF;
    tick();
    req1_valid = 1'b0;
    tick(); tick();
    check("sext_count", seen_data.size(), 32'd2);
    if (seen_data.size() == 2) begin
      check("sext_p0_data", seen_data[0], 32'hFFFF8888);
      check("sext_p0_id", {31'd0, seen_id[0]}, 32'd0);
      check("sext_p1_data", seen_data[1], 32'h00007FFF);
      check("sext_p1_id", {31'd0, seen_id[1]}, 32'd1);
    end

    // Contention after reset: strict alternation starting with port 0.
    do_reset();
    clear_log();
    req0_valid = 1'b1; req0_data = 16'h0001;
    req1_valid = 1'b1; req1_data = 16'hFFFE;
    repeat (6) tick();
    idle_inputs();
    tick(); tick();
    check("contend_count", seen_data.size(), 32'd6);
    for (int i = 0; i < 6 && i < seen_data.size(); i++) begin
      check("contend_id", {31'd0, seen_id[i]}, i % 2);
      check("contend_data", seen_data[i], (i % 2) ? 32'hFFFFFFFE : 32'h00000001);
    end

    // Backpressure with both ports waiting, then drain+refill together.
    do_reset();
    clear_log();
    req0_valid = 1'b1; req0_data = 16'h8000;
    tick();
    rsp_ready = 1'b0;
    req0_data = 16'h0001;
    req1_valid = 1'b1; req1_data = 16'h0002;
    repeat (3) begin
      tick();
      check("bp_ready0", {31'd0, req0_ready}, 32'd0);
      check("bp_ready1", {31'd0, req1_ready}, 32'd0);
      check("bp_hold_data", rsp_data, 32'hFFFF8000);
      check("bp_hold_id", {31'd0, rsp_id}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_refill_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_refill_data", rsp_data, 32'h00000002);
    check("bp_refill_id", {31'd0, rsp_id}, 32'd1);
    req1_valid = 1'b0;
    tick();
    idle_inputs();
    tick(); tick();
    check("bp_count", seen_data.size(), 32'd3);

    // Zero-extend request on port 1.
    clear_log();
    req1_valid = 1'b1; req1_data = 16'h8888; req1_zext = 1'b1;
    tick();
    idle_inputs();
    tick(); tick();
    exp_d = ZEXT ? 32'h00008888 : 32'hFFFF8888;
    check("zext_count", seen_data.size(), 32'd1);
    if (seen_data.size() == 1) check("zext_data", seen_data[0], exp_d);

    // Reset while holding a result.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h1234;
    tick();
    req0_valid = 1'b0;
    tick();
    check("hold_before_rst", {31'd0, rsp_valid}, 32'd1);
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h0005;
    req1_valid = 1'b1; req1_data = 16'h0006;
    tick();
    check("post_rst_first_id", {31'd0, rsp_id}, 32'd0);
    check("post_rst_first_data", rsp_data, 32'h00000005);
    req0_valid = 1'b0;
    tick();
    idle_inputs();
    tick(); tick();

    // Idle drain.
    req0_valid = 1'b1; req0_data = 16'h0042;
    tick();
    idle_inputs();
    check("drain_valid_hi", {31'd0, rsp_valid}, 32'd1);
    tick();
    check("drain_valid_lo", {31'd0, rsp_valid}, 32'd0);
    check("drain_ready0", {31'd0, req0_ready}, 32'd0);
    check("drain_ready1", {31'd0, req1_ready}, 32'd0);

    // Randomized traffic; requesters hold valid/data until accepted.
    p0 = 1'b0;
    p1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (acc0 || rst) p0 = 1'b0;
      if (acc1 || rst) p1 = 1'b0;
      rst = ($urandom_range(0, 199) == 0);
      if (!p0) begin
        p0 = ($urandom_range(0, 1) == 1);
        req0_data = 16'($urandom);
        req0_zext = 1'($urandom);
      end
      if (!p1) begin
        p1 = ($urandom_range(0, 1) == 1);
        req1_data = 16'($urandom);
        req1_zext = 1'($urandom);
      end
      req0_valid = p0;
      req1_valid = p1;
      rsp_ready  = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    rsp_ready = 1'b1;
    repeat (4) tick();
    check("final_queue_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

Shares one 16-to-32-bit immediate extender between two requesters: branch-offset generation (port 0) and the ALU immediate path (port 1). Requests are round-robin arbitrated, extended, and held in a single-entry registered output buffer until the consumer accepts them. The block sits between decode and the execute/branch units. It instantiates `sign_extend_16x32` internally as the extension datapath.

## Interface
Parameters:
- `IN_W`, 16: immediate input width.
- `OUT_W`, 32: extended result width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  port 0 request present.
- `req0_data`  in  IN_W  port 0 immediate.
- `req0_zext`  in  1  port 0 zero-extend select.
- `req0_ready`  out  1  port 0 request accepted this cycle.
- `req1_valid`, `req1_data`, `req1_zext`, `req1_ready`: port 1 equivalents.
- `rsp_valid`  out  1  output buffer holds a result.
- `rsp_ready`  in  1  consumer takes the result this cycle.
- `rsp_data`  out  OUT_W  extended result.
- `rsp_id`  out  1  originating port of `rsp_data` (0 or 1).

## Operation
- FSM has two states: EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
- `can_accept` = (state==EMPTY) | `rsp_ready`.
- Grant selection is combinational:
  - Only one port valid: that port is granted.
  - Both valid: the port not recorded in `last_grant` is granted.
  - Neither valid: no grant.
- `reqN_ready` = grant_N & `can_accept`. Ready is never asserted for a non-valid port.
- Accept means `reqN_valid` & `reqN_ready`. On accept:
  - `rsp_data` is loaded with extend(`reqN_data`).
  - `rsp_id` is loaded with N.
  - `last_grant` is loaded with N.
  - State becomes FULL.
- FULL & `rsp_ready` & no accept: state becomes EMPTY. `rsp_data` and `rsp_id` keep their last values.
- FULL & !`rsp_ready`: no accept. `rsp_data` and `rsp_id` are held stable.
- Extension rule:
  - Default: `rsp_data` = {16{data[15]}, data}.
  - Zero-extend (if enabled, see Configuration): {16'h0, data}.
- `last_grant` changes only on accept.
- Requesters must hold `valid` and `data` stable until ready. The block does not check this.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0.
  - `last_grant`=1, so port 0 wins the first contention.
  - state EMPTY.
  - `req0_ready` and `req1_ready` are 0 during reset.
- Latency: a request accepted at edge N gives `rsp_valid`=1 and the result from cycle N+1.
- Throughput: one result per cycle while `rsp_ready`=1. Drain and refill in the same cycle is allowed, with no bubble.
- Both ports valid continuously with `rsp_ready`=1: grants alternate 0,1,0,1…
- One port valid continuously and the other idle: that port is granted every cycle (no forced alternation).
- Reset asserted mid-operation: the held result is discarded, all outputs return to reset values at the next edge, and no accept occurs in that cycle.
- `reqN_ready` depends combinationally on `rsp_ready` and the valids. There is no combinational path from data inputs to ready.

## Configuration
- Macro `IMM_ARB_ZEXT_EN`.
- Defined: `reqN_zext`=1 selects zero-extension for that request.
- Undefined: the `reqN_zext` ports remain in the port list but are ignored, and every request is sign-extended.

## Test plan
- Sign extension: after reset, port 0 sends 16'h8888 with zext=0 and `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_data`=32'hFFFF8888, `rsp_id`=0. Port 1 sends 16'h7FFF → 32'h00007FFF, `rsp_id`=1.
- Contention after reset: both ports valid, port 0 data 16'h0001 and port 1 data 16'hFFFE, `rsp_ready`=1.
  - First accept is port 0: result 32'h00000001.
  - Next accept is port 1: result 32'hFFFFFFFE.
  - Four further cycles with both valid alternate 0,1,0,1.
- Backpressure: buffer FULL with 32'hFFFF8000, `rsp_ready`=0 for 3 cycles with both ports valid → both readys stay 0, and `rsp_data` and `rsp_id` remain stable. Raising `rsp_ready` gives a drain and an accept in the same cycle, with no idle cycle.
- Zero-extend: port 1 sends 16'h8888 with zext=1.
  - With `IMM_ARB_ZEXT_EN` defined → 32'h00008888.
  - Without the macro → 32'hFFFF8888.
- Reset mid-hold: FULL with `rsp_ready`=0, assert `rst` for 1 cycle → `rsp_valid`=0 and `rsp_data`=0. After release, contention grants port 0 first.
- Idle drain: a single accept followed by `rsp_ready`=1 and no valids → `rsp_valid` falls after one cycle, and both readys stay 0.
